// File: rtl/npc_pkg.sv
// npc_pkg: shared npcOP codes, CP0 register numbers, ExcCodes and FSM states
package npc_pkg;
   typedef enum logic [2:0] {
      NPC_SEQ = 3'b000,
      NPC_BR  = 3'b001,
      NPC_J   = 3'b010,
      NPC_JR  = 3'b011,
      NPC_VEC = 3'b100,
      NPC_EPC = 3'b101
   } npc_op_e;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   typedef enum logic {S_RUN, S_VECTOR} state_e;
endpackage

// File: rtl/npc_seq_cp0_regs.sv
// cp0_regs: SR/Cause/EPC storage, mfc0 read mux and trap-over-mtc0 write priority
module cp0_regs
   import npc_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h0000_0C50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  hw_int_i,
   input  logic        trap_i,
   input  logic [29:0] trap_epc_i,
   input  logic [4:0]  trap_code_i,
   input  logic        eret_i,
   input  logic        cp0_we_i,
   input  logic [4:0]  cp0_addr_i,
   input  logic [31:0] cp0_wd_i,
   output logic [31:0] cp0_rd_o,
   output logic [31:0] epc_o,
   output logic        int_pend_o
);
   logic [5:0]  im_q, im_d, ip_q;
   logic        ie_q, ie_d, exl_q, exl_d;
   logic [4:0]  code_q, code_d;
   logic [29:0] epc_q, epc_d;

   // Later assignments win: trap over eret over mtc0 for EXL/EPC/ExcCode.
   always_comb begin
      im_d   = im_q;
      ie_d   = ie_q;
      exl_d  = exl_q;
      epc_d  = epc_q;
      code_d = code_q;
      if (cp0_we_i && cp0_addr_i == CP0_SR) begin
         im_d  = cp0_wd_i[15:10];
         ie_d  = cp0_wd_i[0];
         exl_d = cp0_wd_i[1];
      end
      if (cp0_we_i && cp0_addr_i == CP0_EPC) epc_d = cp0_wd_i[31:2];
      if (eret_i) exl_d = 1'b0;
      if (trap_i) begin
         exl_d  = 1'b1;
         epc_d  = trap_epc_i;
         code_d = trap_code_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         im_q   <= '0;
         ie_q   <= 1'b0;
         exl_q  <= 1'b0;
         ip_q   <= '0;
         code_q <= '0;
         epc_q  <= '0;
      end else begin
         im_q   <= im_d;
         ie_q   <= ie_d;
         exl_q  <= exl_d;
         ip_q   <= hw_int_i;
         code_q <= code_d;
         epc_q  <= epc_d;
      end
   end

   assign epc_o      = {epc_q, 2'b00};
   assign int_pend_o = |(ip_q & im_q) & ie_q & ~exl_q;
   assign cp0_rd_o   = cp0_addr_i == CP0_SR    ? {16'b0, im_q, 8'b0, exl_q, ie_q} :
                       cp0_addr_i == CP0_CAUSE ? {16'b0, ip_q, 3'b0, code_q, 2'b00} :
                       cp0_addr_i == CP0_EPC   ? epc_o :
                       cp0_addr_i == CP0_PRID  ? PRID : 32'b0;
endmodule

// File: rtl/npc_seq.sv
// npc_seq: next-PC select, PC write enable and exception/interrupt trap sequencing
module npc_seq
   import npc_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h0000_0C50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_done_i,
   input  logic        br_taken_i,
   input  logic        jmp_i,
   input  logic        jr_i,
   input  logic        eret_i,
   input  logic        exc_req_i,
   input  logic [4:0]  exc_code_i,
   input  logic [5:0]  hw_int_i,
   input  logic [29:0] pc_i,
   input  logic        cp0_we_i,
   input  logic [4:0]  cp0_addr_i,
   input  logic [31:0] cp0_wd_i,
   output logic [31:0] cp0_rd_o,
   output logic [2:0]  npc_op_o,
   output logic        pc_write_o,
   output logic [31:0] epc_o,
   output logic        exc_taken_o
);
   state_e state_q;
   logic   run_done, ctl, exc_trap, int_trap, trap, commit, int_pend;

   assign run_done = state_q == S_RUN && instr_done_i;
   assign ctl      = br_taken_i | jmp_i | jr_i | eret_i;
   assign exc_trap = run_done & exc_req_i;
   // Interrupts never break a control transfer; they wait for the next boundary.
   assign int_trap = run_done & ~exc_req_i & int_pend & ~ctl;
   assign trap     = exc_trap | int_trap;
   assign commit   = run_done & ~trap;

   assign exc_taken_o = exc_trap;
   assign pc_write_o  = state_q == S_VECTOR || commit;
   assign npc_op_o    = state_q == S_VECTOR ? NPC_VEC :
                        !commit             ? NPC_SEQ :
                        eret_i              ? NPC_EPC :
                        br_taken_i          ? NPC_BR  :
                        jmp_i               ? NPC_J   :
                        jr_i                ? NPC_JR  : NPC_SEQ;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= trap ? S_VECTOR : S_RUN;
   end

   cp0_regs #(.PRID(PRID)) u_cp0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .hw_int_i    (hw_int_i),
      .trap_i      (trap),
      .trap_epc_i  (exc_req_i ? pc_i : pc_i + 30'd1),
      .trap_code_i (exc_req_i ? exc_code_i : EXC_INT),
      .eret_i      (commit & eret_i),
      .cp0_we_i    (cp0_we_i),
      .cp0_addr_i  (cp0_addr_i),
      .cp0_wd_i    (cp0_wd_i),
      .cp0_rd_o    (cp0_rd_o),
      .epc_o       (epc_o),
      .int_pend_o  (int_pend)
   );
endmodule

// File: tb/tb_npc_seq.sv
// tb_npc_seq: directed scenarios plus randomized run against a CP0/next-PC reference model
module tb_npc_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_done, br_taken, jmp, jr, eret, exc_req, cp0_we;
   logic [4:0]  exc_code, cp0_addr;
   logic [5:0]  hw_int;
   logic [29:0] pc;
   logic [31:0] cp0_wd, cp0_rd, epc;
   logic [2:0]  npc_op;
   logic        pc_write, exc_taken;
   int          checks = 0, passes = 0;

   // reference model state
   logic [5:0]  m_im, m_ip;
   logic        m_ie, m_exl, m_vec;
   logic [4:0]  m_code;
   logic [31:0] m_epc;

   always #5 clk = ~clk;

   npc_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_done_i (instr_done),
      .br_taken_i   (br_taken),
      .jmp_i        (jmp),
      .jr_i         (jr),
      .eret_i       (eret),
      .exc_req_i    (exc_req),
      .exc_code_i   (exc_code),
      .hw_int_i     (hw_int),
      .pc_i         (pc),
      .cp0_we_i     (cp0_we),
      .cp0_addr_i   (cp0_addr),
      .cp0_wd_i     (cp0_wd),
      .cp0_rd_o     (cp0_rd),
      .npc_op_o     (npc_op),
      .pc_write_o   (pc_write),
      .epc_o        (epc),
      .exc_taken_o  (exc_taken)
   );

   task automatic idle();
      instr_done = 0; br_taken = 0; jmp = 0; jr = 0; eret = 0;
      exc_req = 0; exc_code = 0; cp0_we = 0; cp0_addr = 0; cp0_wd = 0;
   endtask

   task automatic model_step();
      logic pend, exc_t, int_t, ctl;
      if (!rst_n) begin
         m_im = 0; m_ie = 0; m_exl = 0; m_ip = 0; m_code = 0; m_epc = 0; m_vec = 0;
         return;
      end
      ctl   = br_taken | jmp | jr | eret;
      pend  = (m_ip & m_im) != 0 && m_ie && !m_exl;
      exc_t = !m_vec && instr_done && exc_req;
      int_t = !m_vec && instr_done && !exc_req && pend && !ctl;
      if (cp0_we && cp0_addr == 12) begin
         m_im = cp0_wd[15:10]; m_ie = cp0_wd[0]; m_exl = cp0_wd[1];
      end
      if (cp0_we && cp0_addr == 14) m_epc = {cp0_wd[31:2], 2'b00};
      if (!m_vec && instr_done && !exc_req && eret) m_exl = 0;
      if (exc_t) begin m_epc = {pc, 2'b00}; m_code = exc_code; m_exl = 1; end
      if (int_t) begin m_epc = {pc + 30'd1, 2'b00}; m_code = 0; m_exl = 1; end
      m_ip  = hw_int;
      m_vec = exc_t | int_t;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle(); hw_int = 0; pc = 0; rst_n = 0;
      tick(); tick();
      #1;
      checks++; if (npc_op !== 3'b000) $display("FAIL reset_op got %b exp 000", npc_op); else passes++;
      checks++; if (pc_write !== 1'b0) $display("FAIL reset_pw got %b exp 0", pc_write); else passes++;
      checks++; if (exc_taken !== 1'b0) $display("FAIL reset_et got %b exp 0", exc_taken); else passes++;
      checks++; if (epc !== 32'h0) $display("FAIL reset_epc got %h exp 0", epc); else passes++;
      rst_n = 1;
      tick();
   endtask

   task automatic test_branch();
      idle(); instr_done = 1; br_taken = 1; cp0_addr = 12;
      #1;
      checks++; if (npc_op !== 3'b001) $display("FAIL br_op got %b exp 001", npc_op); else passes++;
      checks++; if (pc_write !== 1'b1) $display("FAIL br_pw got %b exp 1", pc_write); else passes++;
      checks++; if (exc_taken !== 1'b0) $display("FAIL br_et got %b exp 0", exc_taken); else passes++;
      checks++; if (cp0_rd !== 32'h0) $display("FAIL br_sr got %h exp 0", cp0_rd); else passes++;
      tick(); idle();
   endtask

   task automatic test_exception();
      idle(); pc = 30'h0000_0C01; instr_done = 1; exc_req = 1; exc_code = 12;
      #1;
      checks++; if (exc_taken !== 1'b1) $display("FAIL exc_et got %b exp 1", exc_taken); else passes++;
      checks++; if (pc_write !== 1'b0) $display("FAIL exc_pw got %b exp 0", pc_write); else passes++;
      tick(); idle(); cp0_addr = 13;
      #1;
      checks++; if (npc_op !== 3'b100) $display("FAIL exc_vec_op got %b exp 100", npc_op); else passes++;
      checks++; if (pc_write !== 1'b1) $display("FAIL exc_vec_pw got %b exp 1", pc_write); else passes++;
      checks++; if (epc !== 32'h0000_3004) $display("FAIL exc_epc got %h exp 00003004", epc); else passes++;
      checks++; if (cp0_rd[6:2] !== 5'd12) $display("FAIL exc_code got %0d exp 12", cp0_rd[6:2]); else passes++;
      cp0_addr = 12;
      #1;
      checks++; if (cp0_rd[1] !== 1'b1) $display("FAIL exc_exl got %b exp 1", cp0_rd[1]); else passes++;
      tick();
   endtask

   task automatic test_interrupt();
      idle(); cp0_we = 1; cp0_addr = 12; cp0_wd = 32'h0000_0401; hw_int = 6'b000001;
      tick(); idle(); pc = 30'h100; instr_done = 1;
      #1;
      checks++; if (pc_write !== 1'b0) $display("FAIL int_pw got %b exp 0", pc_write); else passes++;
      checks++; if (exc_taken !== 1'b0) $display("FAIL int_et got %b exp 0", exc_taken); else passes++;
      tick(); idle(); cp0_addr = 13;
      #1;
      checks++; if (npc_op !== 3'b100) $display("FAIL int_vec_op got %b exp 100", npc_op); else passes++;
      checks++; if (epc !== 32'h0000_0404) $display("FAIL int_epc got %h exp 00000404", epc); else passes++;
      checks++; if (cp0_rd[6:2] !== 5'd0) $display("FAIL int_code got %0d exp 0", cp0_rd[6:2]); else passes++;
      tick();
   endtask

   task automatic test_eret();
      idle(); instr_done = 1; eret = 1;
      #1;
      checks++; if (npc_op !== 3'b101) $display("FAIL eret_op got %b exp 101", npc_op); else passes++;
      checks++; if (pc_write !== 1'b1) $display("FAIL eret_pw got %b exp 1", pc_write); else passes++;
      checks++; if (epc !== 32'h0000_0404) $display("FAIL eret_epc got %h exp 00000404", epc); else passes++;
      tick(); idle(); cp0_addr = 12;
      #1;
      checks++; if (cp0_rd[1] !== 1'b0) $display("FAIL eret_exl got %b exp 0", cp0_rd[1]); else passes++;
      tick();
   endtask

   task automatic test_deferred();
      idle(); instr_done = 1; jmp = 1;
      #1;
      checks++; if (npc_op !== 3'b010) $display("FAIL defer_op got %b exp 010", npc_op); else passes++;
      checks++; if (pc_write !== 1'b1) $display("FAIL defer_pw got %b exp 1", pc_write); else passes++;
      tick(); idle(); instr_done = 1; pc = 30'h200;
      #1;
      checks++; if (pc_write !== 1'b0) $display("FAIL defer_trap_pw got %b exp 0", pc_write); else passes++;
      tick(); idle();
      #1;
      checks++; if (npc_op !== 3'b100) $display("FAIL defer_vec_op got %b exp 100", npc_op); else passes++;
      checks++; if (epc !== 32'h0000_0804) $display("FAIL defer_epc got %h exp 00000804", epc); else passes++;
      tick();
   endtask

   task automatic test_reset_vector();
      idle(); instr_done = 1; exc_req = 1; exc_code = 10; pc = 30'h40;
      tick(); idle(); rst_n = 0;
      #1;
      checks++; if (pc_write !== 1'b1) $display("FAIL rstvec_pw got %b exp 1", pc_write); else passes++;
      tick(); rst_n = 1;
      #1;
      checks++; if (pc_write !== 1'b0) $display("FAIL rstvec_after_pw got %b exp 0", pc_write); else passes++;
      checks++; if (npc_op !== 3'b000) $display("FAIL rstvec_after_op got %b exp 000", npc_op); else passes++;
      checks++; if (epc !== 32'h0) $display("FAIL rstvec_epc got %h exp 0", epc); else passes++;
      instr_done = 1; br_taken = 1;
      #1;
      checks++; if (npc_op !== 3'b001) $display("FAIL rstvec_run_op got %b exp 001", npc_op); else passes++;
      tick(); idle();
   endtask

   task automatic test_random();
      logic [2:0]  e_op;
      logic        e_pw, e_et, pend, ctl;
      logic [31:0] e_rd;
      for (int n = 0; n < 600; n++) begin
         idle();
         rst_n      = $urandom_range(0, 63) != 0;
         instr_done = $urandom_range(0, 2) != 0;
         exc_req    = $urandom_range(0, 9) == 0;
         exc_code   = $urandom_range(0, 1) ? 5'd10 : 5'd12;
         case ($urandom_range(0, 5))
            0: br_taken = 1;
            1: jmp = 1;
            2: jr = 1;
            3: eret = 1;
            default: ;
         endcase
         hw_int   = 6'($urandom);
         pc       = 30'($urandom);
         cp0_we   = $urandom_range(0, 3) == 0;
         cp0_addr = 5'($urandom_range(10, 17));
         cp0_wd   = $urandom;
         #1;
         ctl  = br_taken | jmp | jr | eret;
         pend = (m_ip & m_im) != 0 && m_ie && !m_exl;
         e_et = 0; e_pw = 0; e_op = 3'b000;
         if (m_vec) begin e_op = 3'b100; e_pw = 1; end
         else if (instr_done && exc_req) e_et = 1;
         else if (instr_done && !(pend && !ctl)) begin
            e_pw = 1;
            e_op = eret ? 3'b101 : br_taken ? 3'b001 : jmp ? 3'b010 : jr ? 3'b011 : 3'b000;
         end
         case (cp0_addr)
            12: e_rd = {16'b0, m_im, 8'b0, m_exl, m_ie};
            13: e_rd = {16'b0, m_ip, 3'b0, m_code, 2'b00};
            14: e_rd = m_epc;
            15: e_rd = 32'h0000_0C50;
            default: e_rd = 0;
         endcase
         checks++; if (npc_op !== e_op) $display("FAIL rnd_op[%0d] got %b exp %b", n, npc_op, e_op); else passes++;
         checks++; if (pc_write !== e_pw) $display("FAIL rnd_pw[%0d] got %b exp %b", n, pc_write, e_pw); else passes++;
         checks++; if (exc_taken !== e_et) $display("FAIL rnd_et[%0d] got %b exp %b", n, exc_taken, e_et); else passes++;
         checks++; if (cp0_rd !== e_rd) $display("FAIL rnd_rd[%0d] addr %0d got %h exp %h", n, cp0_addr, cp0_rd, e_rd); else passes++;
         checks++; if (epc !== m_epc) $display("FAIL rnd_epc[%0d] got %h exp %h", n, epc, m_epc); else passes++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_exception();
      test_interrupt();
      test_eret();
      test_deferred();
      test_reset_vector();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/npc_seq.md
# npc_seq

Next-PC sequencer and exception controller for the multi-cycle MIPS core. It sits between the main control unit and the `NPC` unit. On each instruction boundary it drives `npcOP` and `pcWrite`, and it owns the CP0 registers `SR`, `Cause`, `EPC` and `PRId`. It also decides when an exception or hardware interrupt redirects the PC to the fixed vector `0x00004180`, and when `eret` returns through `EPC`.

## Interface
- `PRID`, default 32'h0000_0C50, value returned for CP0 register 15.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instrDone` in 1: the current instruction completes this cycle; one pulse per instruction.
- `brTaken` in 1: branch taken; qualified by `instrDone`.
- `jmp` in 1: `j`/`jal`; qualified by `instrDone`.
- `jr` in 1: `jr`/`jalr`; qualified by `instrDone`.
- `eret` in 1: `eret`; qualified by `instrDone`.
- `excReq` in 1: synchronous exception (overflow, reserved instruction); qualified by `instrDone`.
- `excCode` in 5: ExcCode for `excReq`.
- `hwInt` in 6: level-sensitive external interrupt lines.
- `pc` in 30: current PC[31:2].
- `cp0We` in 1: `mtc0` write strobe.
- `cp0Addr` in 5: CP0 register number.
- `cp0Wd` in 32: `mtc0` write data.
- `cp0Rd` out 32: `mfc0` read data; combinational from `cp0Addr`.
- `npcOP` out 3: select code driven to `NPC`.
- `pcWrite` out 1: PC register load enable.
- `epc` out 32: `EPC` register value, driven to `NPC`.
- `excTaken` out 1: squash the current instruction's register and memory writeback.

## Operation
- CP0 registers:
  - `SR` (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - `Cause` (13): IP[15:10], ExcCode[6:2]. Read-only to `mtc0`.
  - `EPC` (14): bits [1:0] are always 0.
  - `PRId` (15) = `PRID`.
  - Any other address reads 0. `mtc0` to any register other than 12 or 14 is ignored.
- `Cause.IP` is registered from `hwInt` every cycle.
- `intPend` = |(`Cause.IP` & `SR.IM`) & `SR.IE` & !`SR.EXL`.
- FSM states:
  - **RUN**: reset state.
  - **VECTOR**: entered only on a trap; one cycle long.
- RUN, `instrDone`=1, evaluated in priority order (first match wins):
  1. `excReq`: `excTaken`=1, `pcWrite`=0. `EPC`←{pc,2'b00}, `Cause.ExcCode`←`excCode`, `SR.EXL`←1. Go to VECTOR.
  2. `intPend` and none of `brTaken`/`jmp`/`jr`/`eret`: the instruction commits, `pcWrite`=0. `EPC`←{pc+1,2'b00}, ExcCode←0, EXL←1. Go to VECTOR.
  3. `eret`: `npcOP`=101, `pcWrite`=1, `SR.EXL`←0.
  4. Otherwise: `npcOP` = 001 if `brTaken`, 010 if `jmp`, 011 if `jr`, else 000. `pcWrite`=1.
- An interrupt that arrives with a control-transfer instruction is deferred to the next boundary.
- RUN, `instrDone`=0: `pcWrite`=0, `npcOP`=000.
- VECTOR: `npcOP`=100, `pcWrite`=1, return to RUN. `instrDone` is ignored in this state.
- `mtc0` and a trap on the same edge: the trap's updates to EXL, EPC and ExcCode win. A write to `SR.IM`/`SR.IE` on that edge still lands.
- Several of `brTaken`/`jmp`/`jr` asserted at once is illegal; the priority given above applies.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `SR`, `Cause`, `EPC` ← 0; state ← RUN.
  - Outputs: `npcOP`=000, `pcWrite`=0, `excTaken`=0, `epc`=0.
  - Reset during VECTOR abandons the vector load.
- `npcOP`, `pcWrite` and `excTaken` are combinational from state and inputs, valid in the same cycle as `instrDone`.
- Trap latency: the PC loads the vector exactly 1 cycle after the trapping `instrDone`.
- `hwInt` to `intPend`: 1-cycle registration latency.
- CP0 writes are visible on `cp0Rd` and `epc` in the cycle after `cp0We`.

## Structure
- Shared package `npc_pkg`:
  - `npcOP` codes: SEQ 000, BR 001, J 010, JR 011, VEC 100, EPC 101.
  - CP0 register numbers 12–15.
  - ExcCodes: Int 0, RI 10, Ov 12.
  - FSM state typedef.
- One sub-module, `cp0_regs`, holds `SR`/`Cause`/`EPC` with the read mux and the write-priority logic.
- The FSM and the `npcOP` decode stay in `npc_seq`.

## Test plan
- Reset, then `instrDone` with `brTaken`=1 → `npcOP`=001, `pcWrite`=1, `excTaken`=0, `cp0Rd`(12)=0.
- `pc`=30'h0000_0C01, `excReq`=1, `excCode`=12 → `excTaken`=1. Next cycle: `npcOP`=100, `pcWrite`=1, `epc`=0x0000_3004, `Cause`[6:2]=12, `SR`[1]=1.
- `mtc0` `SR`←0x0000_0401, `hwInt`[0]=1, then non-branch `instrDone` at `pc`=30'h100 → `EPC`=0x0000_0404, vector load next cycle, ExcCode=0.
- Same pending interrupt with `jmp`=1 → `npcOP`=010 with no trap; the trap fires at the following plain `instrDone`.
- `eret` with EXL=1, `EPC`=0x0000_0404 → `npcOP`=101, `pcWrite`=1. `SR`[1]=0 next cycle.
- `rst_n`=0 during VECTOR → next cycle `pcWrite`=0, state RUN, `epc`=0.
